// File: rtl/shift_unit_iter.sv
// Iterative shifter: LSL/LSR/ASR/ROR by 0..N-1 bits, at most STEP bits per clock.
// Uses a start/in_ready handshake for requests and out_valid/out_ready for results.
module shift_unit_iter #(
  parameter int N    = 64,
  parameter int STEP = 4,
  localparam int SW  = $clog2(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [N-1:0]  a,
  input  logic [SW-1:0] shamt,
  input  logic [1:0]    op,
  output logic          in_ready,
  output logic          busy,
  output logic [N-1:0]  y,
  output logic          out_valid,
  input  logic          out_ready
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [SW:0] STEPX = (SW+1)'(STEP);

  state_t        state;
  logic [N-1:0]  acc;
  logic [N-1:0]  shifted;
  logic [SW-1:0] cnt;
  logic [1:0]    opq;
  logic [SW:0]   cntx;
  logic [SW:0]   k;
  logic [SW:0]   rem;

  // One pass of at most STEP bits; each amount is a fixed wiring pattern, so no wide barrel shifter
  always_comb begin
    cntx    = {1'b0, cnt};
    k       = (cntx < STEPX) ? cntx : STEPX;
    rem     = cntx - k;
    shifted = acc;
    for (int i = 1; i <= STEP; i++) begin
      if (k == (SW+1)'(i)) begin
        case (opq)
          2'b00: shifted = acc << i;
          2'b01: shifted = acc >> i;
          2'b10: shifted = $signed(acc) >>> i;
          2'b11: shifted = (acc >> i) | (acc << (N - i));
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      opq       <= '0;
      y         <= '0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc      <= a;
            cnt      <= shamt;
            opq      <= op;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            if (shamt == '0) begin
              y         <= a;
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          acc <= shifted;
          cnt <= rem[SW-1:0];
          if (rem == '0) begin
            y         <= shifted;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          // Retiring returns to IDLE only; a start seen on this same edge is not taken
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_unit_iter.sv
// Directed checks for shift_unit_iter: N=64/STEP=4 main instance plus a STEP=1 instance.
module tb_shift_unit_iter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [63:0] a = '0;
  logic [5:0]  shamt = '0;
  logic [1:0]  op = '0;
  logic        in_ready, busy, out_valid;
  logic [63:0] y;
  logic        out_ready = 1'b0;

  logic        start1 = 1'b0;
  logic [63:0] a1 = '0;
  logic [5:0]  shamt1 = '0;
  logic [1:0]  op1 = '0;
  logic        in_ready1, busy1, out_valid1;
  logic [63:0] y1;
  logic        out_ready1 = 1'b0;

  int checks = 0;
  int fails  = 0;

  shift_unit_iter #(.N(64), .STEP(4)) dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .shamt(shamt), .op(op),
    .in_ready(in_ready), .busy(busy), .y(y), .out_valid(out_valid), .out_ready(out_ready)
  );

  shift_unit_iter #(.N(64), .STEP(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .a(a1), .shamt(shamt1), .op(op1),
    .in_ready(in_ready1), .busy(busy1), .y(y1), .out_valid(out_valid1), .out_ready(out_ready1)
  );

  always #5 clk = ~clk;

  // Present a request for one edge, then scramble the operands so in-flight isolation is exercised
  task automatic issue(input logic [1:0] o, input logic [63:0] av, input logic [5:0] sh);
    int guard = 0;
    while (!in_ready && guard < 100) begin
      @(posedge clk); #1; guard++;
    end
    @(negedge clk);
    start = 1'b1; a = av; shamt = sh; op = o;
    @(posedge clk); #1;
    start = 1'b0; a = ~av; shamt = ~sh; op = ~o;
  endtask

  // Edges after the accept edge until out_valid; 0 means visible right after accept
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic retire();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (y !== 64'h0) begin fails++; $display("[TB] FAIL reset_y: got %h expected %h", y, 64'h0); end
    checks++; if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_valid: got %b expected 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin fails++; $display("[TB] FAIL reset_ready: got %b expected 1", in_ready); end
    checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_lsl();
    int lat;
    issue(2'b00, 64'h1, 6'd2);
    checks++; if (in_ready !== 1'b0) begin fails++; $display("[TB] FAIL lsl_ready_low: got %b expected 0", in_ready); end
    wait_valid(lat);
    checks++; if (y !== 64'h4) begin fails++; $display("[TB] FAIL lsl_y: got %h expected %h", y, 64'h4); end
    checks++; if (lat != 1) begin fails++; $display("[TB] FAIL lsl_lat: got %0d expected 1", lat); end
    checks++; if (busy !== 1'b1) begin fails++; $display("[TB] FAIL lsl_busy_done: got %b expected 1", busy); end
    retire();
    checks++; if (in_ready !== 1'b1) begin fails++; $display("[TB] FAIL lsl_retire_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_asr();
    int lat;
    issue(2'b10, 64'h8000_0000_0000_0000, 6'd63);
    wait_valid(lat);
    checks++; if (y !== 64'hFFFF_FFFF_FFFF_FFFF) begin fails++; $display("[TB] FAIL asr63_y: got %h expected %h", y, 64'hFFFF_FFFF_FFFF_FFFF); end
    checks++; if (lat != 16) begin fails++; $display("[TB] FAIL asr63_lat: got %0d expected 16", lat); end
    retire();
  endtask

  task automatic test_ror_lsr();
    int lat;
    issue(2'b11, 64'h1, 6'd1);
    wait_valid(lat);
    checks++; if (y !== 64'h8000_0000_0000_0000) begin fails++; $display("[TB] FAIL ror1_y: got %h expected %h", y, 64'h8000_0000_0000_0000); end
    retire();
    issue(2'b01, 64'h1, 6'd1);
    wait_valid(lat);
    checks++; if (y !== 64'h0) begin fails++; $display("[TB] FAIL lsr1_y: got %h expected %h", y, 64'h0); end
    retire();
  endtask

  task automatic test_zero_shift();
    int lat;
    for (int o = 0; o < 4; o++) begin
      issue(o[1:0], 64'hDEAD_BEEF_0123_4567, 6'd0);
      wait_valid(lat);
      checks++; if (y !== 64'hDEAD_BEEF_0123_4567) begin fails++; $display("[TB] FAIL zero_y op%0d: got %h expected %h", o, y, 64'hDEAD_BEEF_0123_4567); end
      checks++; if (lat != 0) begin fails++; $display("[TB] FAIL zero_lat op%0d: got %0d expected 0", o, lat); end
      retire();
    end
  endtask

  task automatic test_vectors();
    logic [1:0]  vop [4] = '{2'b11, 2'b10, 2'b00, 2'b01};
    logic [63:0] va  [4] = '{64'h0123_4567_89AB_CDEF, 64'h7000_0000_0000_0000, 64'hFF, 64'hFFFF_0000_0000_0000};
    logic [5:0]  vs  [4] = '{6'd8, 6'd5, 6'd63, 6'd17};
    logic [63:0] vy  [4] = '{64'hEF01_2345_6789_ABCD, 64'h0380_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h0000_7FFF_8000_0000};
    int          vl  [4] = '{2, 2, 16, 5};
    int lat;
    for (int i = 0; i < 4; i++) begin
      issue(vop[i], va[i], vs[i]);
      wait_valid(lat);
      checks++; if (y !== vy[i]) begin fails++; $display("[TB] FAIL vec%0d_y: got %h expected %h", i, y, vy[i]); end
      checks++; if (lat != vl[i]) begin fails++; $display("[TB] FAIL vec%0d_lat: got %0d expected %0d", i, lat, vl[i]); end
      retire();
    end
  endtask

  task automatic test_early_ready();
    int lat;
    out_ready = 1'b1;
    issue(2'b00, 64'h5, 6'd8);
    wait_valid(lat);
    checks++; if (y !== 64'h500) begin fails++; $display("[TB] FAIL early_ready_y: got %h expected %h", y, 64'h500); end
    checks++; if (lat != 2) begin fails++; $display("[TB] FAIL early_ready_lat: got %0d expected 2", lat); end
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++; if (in_ready !== 1'b1) begin fails++; $display("[TB] FAIL early_ready_idle: got %b expected 1", in_ready); end
  endtask

  task automatic test_hold();
    int lat;
    issue(2'b00, 64'h1, 6'd2);
    wait_valid(lat);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      start = 1'b1; a = 64'hAAAA_0000_0000_0000 + 64'(c); shamt = 6'd0; op = 2'b01;
      @(posedge clk); #1;
      checks++; if (y !== 64'h4 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        fails++; $display("[TB] FAIL hold_c%0d: got y=%h v=%b r=%b expected y=%h v=1 r=0", c, y, out_valid, in_ready, 64'h4);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      fails++; $display("[TB] FAIL hold_release: got r=%b v=%b expected r=1 v=0", in_ready, out_valid);
    end
    start = 1'b0;
  endtask

  task automatic test_reset_mid();
    int lat;
    issue(2'b10, 64'h8000_0000_0000_0000, 6'd40);
    repeat (2) begin @(posedge clk); #1; end
    checks++; if (busy !== 1'b1 || out_valid !== 1'b0) begin fails++; $display("[TB] FAIL midrst_pre: got busy=%b v=%b expected busy=1 v=0", busy, out_valid); end
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++; if (y !== 64'h0) begin fails++; $display("[TB] FAIL midrst_y: got %h expected %h", y, 64'h0); end
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      fails++; $display("[TB] FAIL midrst_flags: got v=%b r=%b busy=%b expected v=0 r=1 busy=0", out_valid, in_ready, busy);
    end
    @(negedge clk);
    reset = 1'b0;
    issue(2'b00, 64'h3, 6'd4);
    wait_valid(lat);
    checks++; if (y !== 64'h30) begin fails++; $display("[TB] FAIL midrst_next_y: got %h expected %h", y, 64'h30); end
    retire();
  endtask

  task automatic test_back_to_back();
    int lat;
    issue(2'b00, 64'h1, 6'd4);
    wait_valid(lat);
    checks++; if (y !== 64'h10) begin fails++; $display("[TB] FAIL b2b_first_y: got %h expected %h", y, 64'h10); end
    retire();
    issue(2'b01, 64'h100, 6'd3);
    wait_valid(lat);
    checks++; if (y !== 64'h20) begin fails++; $display("[TB] FAIL b2b_second_y: got %h expected %h", y, 64'h20); end
    checks++; if (lat != 1) begin fails++; $display("[TB] FAIL b2b_second_lat: got %0d expected 1", lat); end
    retire();
  endtask

  task automatic test_step1();
    int lat = 0;
    @(negedge clk);
    start1 = 1'b1; a1 = 64'hF0; shamt1 = 6'd5; op1 = 2'b01;
    @(posedge clk); #1;
    start1 = 1'b0; a1 = '0; shamt1 = '0; op1 = '0;
    while (!out_valid1 && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    checks++; if (y1 !== 64'h7) begin fails++; $display("[TB] FAIL step1_y: got %h expected %h", y1, 64'h7); end
    checks++; if (lat != 5) begin fails++; $display("[TB] FAIL step1_lat: got %0d expected 5", lat); end
    out_ready1 = 1'b1;
    @(posedge clk); #1;
    out_ready1 = 1'b0;
    checks++; if (in_ready1 !== 1'b1) begin fails++; $display("[TB] FAIL step1_idle: got %b expected 1", in_ready1); end
  endtask

  initial begin
    test_reset();
    test_lsl();
    test_asr();
    test_ror_lsr();
    test_zero_shift();
    test_vectors();
    test_early_ready();
    test_hold();
    test_reset_mid();
    test_back_to_back();
    test_step1();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
